ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Parametrised instruction-fetch stage. Owns the program counter and drives a synchronous-read instruction ROM with 1-cycle latency, which sits outside this block.
- Presents the fetched instruction, its PC and PC+4 to decode, with a valid flag.
- Supports stall, conditional branch, absolute jump and register jump.
- Replaces the fixed 32-bit, branch-only PC/ROM fetch block.

Parameters:
- XLEN, 32, PC and instruction width.
- ADDR_W, 14, ROM word-address width. The ROM word address is pc[ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; hold the current instruction.
- branch_taken  in  1  conditional branch resolved taken (Branch AND zero); qualifies branch_offset.
- branch_offset  in  XLEN  sign-extended word offset of the branch.
- jump  in  1  absolute jump.
- jump_index  in  26  jump target index.
- jr  in  1  register jump.
- jr_target  in  XLEN  byte address for jr.
- imem_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2].
- imem_rdata  in  XLEN  ROM data, valid the cycle after imem_addr.
- instr  out  XLEN  current instruction.
- instr_pc  out  XLEN  PC of instr.
- pc_plus4  out  XLEN  instr_pc+4.
- instr_valid  out  1  instr is a live, non-squashed instruction.

Behaviour:
- Registers:
  - pc: the address presented to the ROM.
  - fetch_pc: the PC of the data now on imem_rdata.
  - hold_instr: skid buffer.
  - state: one of BOOT, RUN, HOLD, BUBBLE.
- Reset (async):
  - pc=RESET_PC, fetch_pc=RESET_PC, hold_instr=0, state=BOOT.
  - Outputs: instr_valid=0, instr=0, instr_pc=RESET_PC, pc_plus4=RESET_PC+4.
  - Reset asserted mid-operation discards any stall or redirect in progress.
- Output muxing:
  - instr = hold_instr in HOLD, imem_rdata otherwise; forced to 0 when instr_valid=0.
  - instr_valid=1 in RUN and HOLD, 0 in BOOT and BUBBLE.
- Redirect target (byte addresses, mod 2^XLEN):
  - Branch: instr_pc+4+(branch_offset<<2).
  - Jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - jr: jr_target.
  - Priority jr > jump > branch_taken.
  - Redirect inputs are ignored when instr_valid=0.
- BOOT/BUBBLE:
  - pc<=pc+4, fetch_pc<=pc, next state RUN.
  - stall is ignored because there is nothing valid to hold.
  - First valid instruction appears 1 cycle after reset release or redirect.
- RUN:
  - Redirect: pc<=target, fetch_pc<=target, state BUBBLE. The wrong-path instruction arriving next cycle is squashed. Redirect wins over a simultaneous stall.
  - Else if stall: hold_instr<=imem_rdata, pc held, state HOLD.
  - Else: pc<=pc+4, fetch_pc<=pc, stay RUN.
- HOLD:
  - instr comes from hold_instr; instr_pc is unchanged.
  - The ROM keeps reading pc (the next instruction).
  - stall=1: stay HOLD.
  - stall=0 without redirect: held instruction is consumed this cycle; pc<=pc+4, fetch_pc<=pc, state RUN. Next cycle shows the ROM data for the old pc.
  - Redirect in HOLD: same action as in RUN, state BUBBLE.
- PC arithmetic wraps modulo 2^XLEN.
- Bits above ADDR_W+1 are ignored for ROM addressing, so the ROM image aliases.
- pc[1:0] is carried unmodified; see the optional feature.
- Throughput: one instruction per cycle when unstalled. Redirect penalty: 1 bubble.

Optional Feature:
- Macro IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign (1 bit), reset 0.
  - Any redirect target with target[1:0]!=0 sets misalign=1 (sticky until reset).
  - pc<=RESET_PC and state BUBBLE instead of jumping to the target.
- Undefined:
  - No port.
  - Target low bits are kept in pc, and the ROM fetches the word-truncated address.

Test Plan:
- Reset release with ROM[0..3]=A,B,C,D, no stall → instr_valid low for 1 cycle, then A,B,C,D on consecutive cycles; instr_pc 0,4,8,12.
- Stall held 3 cycles while B is shown → instr=B, instr_pc=4 for 4 cycles (3 stalled plus the release cycle), then C with instr_pc=8. No instruction lost or duplicated.
- branch_taken with branch_offset=-2 at instr_pc=0x20 → 1 bubble (instr_valid=0), then instruction from 0x1C.
- jump with jump_index=0x40 and jr with jr_target=0x100 asserted together at instr_pc=0x8 → jr wins; bubble, then fetch from 0x100.
- Redirect and stall in the same cycle, and redirect during HOLD → redirect taken, stall ignored, bubble, then the target instruction.
- Reset asserted mid-HOLD, and jr_target=0x102 with IFETCH_MISALIGN_TRAP_EN → outputs return to reset values immediately. For the misaligned jr: misalign=1, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous ROM and presents instructions to decode.
// Optional misaligned-redirect trap is enabled with `define IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 14,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [XLEN-1:0]   jr_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              instr_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, BUBBLE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic            redirect;
    logic [XLEN-1:0] target;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
    assign misalign = misalign_q;
`endif

    assign instr_valid = (state_q == RUN) || (state_q == HOLD);
    assign instr_pc    = fetch_pc_q;
    assign pc_plus4    = fetch_pc_q + XLEN'(4);
    assign imem_addr   = pc_q[ADDR_W+1:2];

    always_comb begin
        instr = '0;
        if (instr_valid) begin
            instr = (state_q == HOLD) ? hold_instr_q : imem_rdata;
        end
    end

    // Redirects are only meaningful for a live instruction; priority jr > jump > branch.
    assign redirect = instr_valid && (jr || jump || branch_taken);

    always_comb begin
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {pc_plus4[XLEN-1:28], jump_index, 2'b00};
        end else begin
            target = pc_plus4 + (branch_offset << 2);
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latches).
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        hold_instr_d = hold_instr_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            BOOT, BUBBLE: begin
                pc_d       = pc_q + XLEN'(4);
                fetch_pc_d = pc_q;
                state_d    = RUN;
            end
            RUN, HOLD: begin
                if (redirect) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        pc_d       = RESET_PC;
                        fetch_pc_d = RESET_PC;
                    end else begin
                        pc_d       = target;
                        fetch_pc_d = target;
                    end
`else
                    pc_d       = target;
                    fetch_pc_d = target;
`endif
                    state_d = BUBBLE;
                end else if (stall) begin
                    // Capture only on entry; the ROM output moves on to the next word while holding.
                    if (state_q == RUN) begin
                        hold_instr_d = imem_rdata;
                    end
                    state_d = HOLD;
                end else begin
                    pc_d       = pc_q + XLEN'(4);
                    fetch_pc_d = pc_q;
                    state_d    = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            hold_instr_q <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_instr_q <= hold_instr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a behavioural 1-cycle ROM whose word at index w is 32'hA500_0000 | w.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_vec;
    int n_err;

    ifetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign     (misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial imem_rdata = 32'h0;
    always @(posedge clk) imem_rdata <= 32'hA500_0000 | {18'h0, imem_addr};

    function automatic logic [31:0] rom_val(input logic [31:0] byte_addr);
        return 32'hA500_0000 | {18'h0, byte_addr[15:2]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jr            = 1'b0;
        jr_target     = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_live(input string name, input logic [31:0] p);
        n_vec++;
        if ({instr_valid, instr, instr_pc, pc_plus4} !== {1'b1, rom_val(p), p, p + 32'd4}) begin
            n_err++;
            $display("FAIL %s: got v=%b instr=%h pc=%h pc4=%h, want v=1 instr=%h pc=%h pc4=%h",
                     name, instr_valid, instr, instr_pc, pc_plus4, rom_val(p), p, p + 32'd4);
        end
    endtask

    task automatic expect_bubble(input string name);
        n_vec++;
        if ({instr_valid, instr} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL %s: got v=%b instr=%h, want v=0 instr=00000000", name, instr_valid, instr);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({instr_valid, instr, instr_pc, pc_plus4, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h4, 14'h0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b instr=%h pc=%h pc4=%h addr=%h, want 0/0/0/4/0",
                     instr_valid, instr, instr_pc, pc_plus4, imem_addr);
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        n_vec++;
        if (misalign !== 1'b0) begin
            n_err++;
            $display("FAIL reset_misalign: got %b want 0", misalign);
        end
`endif
    endtask

    task automatic test_sequential();
        reset_dut();
        expect_bubble("boot_bubble");
        for (int i = 0; i < 4; i++) begin
            step();
            expect_live($sformatf("seq_%0d", i), 32'(i * 4));
        end
    endtask

    task automatic test_stall();
        reset_dut();
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            stall = (k < 3);
            expect_live($sformatf("stall_hold_%0d", k), 32'h4);
            if (k == 1) begin
                n_vec++;
                if (imem_addr !== 14'h2) begin
                    n_err++;
                    $display("FAIL stall_addr: got %h want 0002", imem_addr);
                end
            end
            step();
        end
        expect_live("stall_next_c", 32'h8);
        step();
        expect_live("stall_next_d", 32'hC);
    endtask

    task automatic test_branch();
        reset_dut();
        for (int i = 0; i < 9; i++) step();
        expect_live("br_origin", 32'h20);
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        step();
        expect_bubble("br_bubble");
        step();
        branch_taken = 1'b0;
        expect_live("br_target", 32'h1C);
        step();
        expect_live("br_after", 32'h20);
    endtask

    task automatic test_priority();
        reset_dut();
        for (int i = 0; i < 3; i++) step();
        jump = 1'b1; jump_index = 26'h40;
        jr = 1'b1;   jr_target = 32'h100;
        branch_taken = 1'b1; branch_offset = 32'h5;
        step();
        expect_bubble("prio_jr_bubble");
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        step();
        expect_live("prio_jr_target", 32'h100);
        jump = 1'b1; jump_index = 26'h50;
        branch_taken = 1'b1; branch_offset = 32'h1;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        step();
        expect_live("prio_jump_target", 32'h140);
        jr = 1'b1; jr_target = 32'h200;
        jump = 1'b1; jump_index = 26'h60;
        step();
        jr = 1'b0; jump = 1'b0;
        step();
        expect_live("prio_jr_over_jump", 32'h200);
    endtask

    task automatic test_redirect_stall();
        reset_dut();
        step();
        step();
        stall = 1'b1;
        jump  = 1'b1; jump_index = 26'h10;
        step();
        jump = 1'b0;
        expect_bubble("rs_bubble");
        step();
        expect_live("rs_target", 32'h40);
        step();
        expect_live("rs_hold", 32'h40);
        jr = 1'b1; jr_target = 32'h80;
        step();
        jr = 1'b0; stall = 1'b0;
        expect_bubble("hold_redirect_bubble");
        step();
        expect_live("hold_redirect_target", 32'h80);
        step();
        expect_live("hold_redirect_next", 32'h84);
    endtask

    task automatic test_reset_mid_hold();
        reset_dut();
        step();
        step();
        stall = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({instr_valid, instr, instr_pc, pc_plus4, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h4, 14'h0}) begin
            n_err++;
            $display("FAIL reset_mid_hold: got v=%b instr=%h pc=%h pc4=%h addr=%h, want 0/0/0/4/0",
                     instr_valid, instr, instr_pc, pc_plus4, imem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        step();
        expect_live("reset_restart", 32'h0);
    endtask

    task automatic test_misalign();
        reset_dut();
        for (int i = 0; i < 3; i++) step();
        jr = 1'b1; jr_target = 32'h102;
        step();
        jr = 1'b0;
        expect_bubble("mis_bubble");
`ifdef IFETCH_MISALIGN_TRAP_EN
        n_vec++;
        if (misalign !== 1'b1) begin
            n_err++;
            $display("FAIL mis_flag: got %b want 1", misalign);
        end
        step();
        expect_live("mis_restart", 32'h0);
        step();
        n_vec++;
        if ({misalign, instr_pc} !== {1'b1, 32'h4}) begin
            n_err++;
            $display("FAIL mis_sticky: got misalign=%b pc=%h want 1/00000004", misalign, instr_pc);
        end
`else
        step();
        n_vec++;
        if ({instr_valid, instr, instr_pc, pc_plus4} !== {1'b1, 32'hA500_0040, 32'h102, 32'h106}) begin
            n_err++;
            $display("FAIL mis_truncate: got v=%b instr=%h pc=%h pc4=%h want 1/a5000040/00000102/00000106",
                     instr_valid, instr, instr_pc, pc_plus4);
        end
        step();
        n_vec++;
        if ({instr, instr_pc} !== {32'hA500_0041, 32'h106}) begin
            n_err++;
            $display("FAIL mis_next: got instr=%h pc=%h want a5000041/00000106", instr, instr_pc);
        end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_priority();
        test_redirect_stall();
        test_reset_mid_hold();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
